gshare_btb_predictor: RTL and testbench

Parametrised next-generation branch predictor for the fetch stage.
- Replaces the direct-mapped, PC-compared table pair with a tagged BTB (valid and tag per entry).
- Direction comes from a gshare pattern table of 2-bit saturating counters, indexed by PC XOR speculative global history register (GHR).
- Adds mispredict-driven GHR repair and a post-reset table-initialisation sweep.
- Sits between the PC generator (next_pc/pc) and the EX-stage branch resolution unit.

---
 rtl/gshare_btb_predictor_pkg.sv | 26 ++
 rtl/gshare_btb_predictor_if.sv | 44 ++++
 rtl/gshare_btb_predictor_sat_counter_table.sv | 46 ++++
 rtl/gshare_btb_predictor.sv | 143 ++++++++++++++
 tb/tb_gshare_btb_predictor.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gshare_btb_predictor_pkg.sv
// Shared definitions for the gshare/BTB branch predictor slice.
// Contents: default core address width, 2-bit direction counter encodings,
// predictor FSM state encodings, and the saturating counter step function.
package gshare_btb_predictor_pkg;

  localparam int unsigned CORE_ADDR_WIDTH = 32;

  // 2-bit direction counter encodings
  localparam logic [1:0] SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] WT  = 2'b10;  // weakly taken
  localparam logic [1:0] ST  = 2'b11;  // strongly taken

  // Predictor FSM states
  localparam logic [0:0] FSM_INIT = 1'b0;
  localparam logic [0:0] FSM_RUN  = 1'b1;

  // One training step of a 2-bit saturating counter.
  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == ST) ? ST : cnt + 2'd1;
    end
    return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/gshare_btb_predictor_if.sv
// Fetch-side and EX-side signal bundle of the branch predictor.
// master: core side (drives next_pc/pc/fetch_fire and branch resolution,
//         receives predictions and init_done).
// slave : predictor side.
interface gshare_btb_predictor_if
  import gshare_btb_predictor_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = CORE_ADDR_WIDTH,
  parameter int unsigned GHR_WIDTH  = 8
);

  // fetch side
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  fetch_fire;
  logic                  predict_hit;
  logic                  predict_taken;
  logic [ADDR_WIDTH-1:0] predict_target_pc;
  logic [GHR_WIDTH-1:0]  predict_ghr;
  logic                  init_done;

  // EX resolution side
  logic                  branch_ex;
  logic [ADDR_WIDTH-1:0] branch_pc_ex;
  logic                  branch_taken_ex;
  logic [ADDR_WIDTH-1:0] branch_target_pc;
  logic [GHR_WIDTH-1:0]  branch_ghr_ex;
  logic                  mispredict_ex;

  modport master (
    output next_pc, pc, fetch_fire,
    output branch_ex, branch_pc_ex, branch_taken_ex, branch_target_pc,
    output branch_ghr_ex, mispredict_ex,
    input  predict_hit, predict_taken, predict_target_pc, predict_ghr, init_done
  );

  modport slave (
    input  next_pc, pc, fetch_fire,
    input  branch_ex, branch_pc_ex, branch_taken_ex, branch_target_pc,
    input  branch_ghr_ex, mispredict_ex,
    output predict_hit, predict_taken, predict_target_pc, predict_ghr, init_done
  );

endinterface

// File: rtl/gshare_btb_predictor_sat_counter_table.sv
// ENTRY_NUM x 2-bit saturating direction counter table.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset (read register only)
//   rd_idx_i / rd_cnt_o   registered read port, 1-cycle latency, read-before-write
//   upd_en_i, upd_idx_i,
//   upd_taken_i           read-modify-write saturating training port
//   init_en_i, init_idx_i sweep port, writes weakly not-taken; wins over update
module gshare_btb_predictor_sat_counter_table
  import gshare_btb_predictor_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = 256,
  parameter int unsigned IDX_WIDTH = $clog2(ENTRY_NUM)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_WIDTH-1:0] rd_idx_i,
  output logic [1:0]           rd_cnt_o,
  input  logic                 upd_en_i,
  input  logic [IDX_WIDTH-1:0] upd_idx_i,
  input  logic                 upd_taken_i,
  input  logic                 init_en_i,
  input  logic [IDX_WIDTH-1:0] init_idx_i
);

  logic [1:0] cnt_q [ENTRY_NUM];
  logic [1:0] rd_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q <= '0;
    end else begin
      rd_cnt_q <= cnt_q[rd_idx_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (init_en_i) begin
      cnt_q[init_idx_i] <= WNT;
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= sat_next(cnt_q[upd_idx_i], upd_taken_i);
    end
  end

  assign rd_cnt_o = rd_cnt_q;

endmodule

// File: rtl/gshare_btb_predictor.sv
// gshare direction predictor with a tagged BTB for the fetch stage.
// Ports:
//   cpu_clk, cpu_rst  core clock, synchronous active-high reset
//   bp (slave)        next_pc/pc/fetch_fire lookup side, predict_* results
//                     (one cycle after next_pc), init_done, and the EX-stage
//                     branch resolution / mispredict repair inputs.
// After reset an INIT sweep clears every BTB valid bit and sets every counter
// to weakly not-taken, one entry per cycle; the predictor is live once done.
module gshare_btb_predictor
  import gshare_btb_predictor_pkg::*;
#(
  parameter int unsigned ENTRY_NUM  = 256,
  parameter int unsigned IDX_WIDTH  = $clog2(ENTRY_NUM),
  parameter int unsigned GHR_WIDTH  = 8,
  parameter int unsigned TAG_WIDTH  = 10,
  parameter int unsigned ADDR_WIDTH = CORE_ADDR_WIDTH
) (
  input logic                   cpu_clk,
  input logic                   cpu_rst,
  gshare_btb_predictor_if.slave bp
);

  logic [0:0]           state_q, state_d;
  logic [IDX_WIDTH-1:0] sweep_q, sweep_d;
  logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
  logic                 run;

  logic [IDX_WIDTH-1:0] bidx, pidx, upd_bidx, upd_pidx;
  logic                 init_wr, upd_en, btb_wr;

  logic                  valid_q [ENTRY_NUM];
  logic [TAG_WIDTH-1:0]  tag_q   [ENTRY_NUM];
  logic [ADDR_WIDTH-1:0] tgt_q   [ENTRY_NUM];

  logic                  valid_r_q;
  logic [TAG_WIDTH-1:0]  tag_r_q;
  logic [ADDR_WIDTH-1:0] tgt_r_q;
  logic [GHR_WIDTH-1:0]  ghr_r_q;
  logic [1:0]            cnt_r;
  logic                  hit, taken;
  logic                  unused_pc_bits;

  assign run = (state_q == FSM_RUN);

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == FSM_INIT) begin
      sweep_d = sweep_q + IDX_WIDTH'(1);
      if (sweep_q == IDX_WIDTH'(ENTRY_NUM - 1)) begin
        state_d = FSM_RUN;
      end
    end
  end

  // Repair from EX outranks the speculative shift of the fetch-stage hit.
  always_comb begin
    ghr_d = ghr_q;
    if (run) begin
      if (bp.branch_ex && bp.mispredict_ex) begin
        ghr_d = {bp.branch_ghr_ex[GHR_WIDTH-2:0], bp.branch_taken_ex};
      end else if (bp.fetch_fire && hit) begin
        ghr_d = {ghr_q[GHR_WIDTH-2:0], taken};
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q <= FSM_INIT;
      sweep_q <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ghr_q   <= ghr_d;
    end
  end

  assign bidx     = bp.next_pc[IDX_WIDTH+1:2];
  assign pidx     = bidx ^ IDX_WIDTH'(ghr_q);
  assign upd_bidx = bp.branch_pc_ex[IDX_WIDTH+1:2];
  assign upd_pidx = upd_bidx ^ IDX_WIDTH'(bp.branch_ghr_ex);

  assign init_wr = !cpu_rst && (state_q == FSM_INIT);
  assign upd_en  = !cpu_rst && run && bp.branch_ex;
  assign btb_wr  = upd_en && bp.branch_taken_ex;

  // Not-taken resolutions leave an existing BTB entry in place.
  always_ff @(posedge cpu_clk) begin
    if (init_wr) begin
      valid_q[sweep_q] <= 1'b0;
    end else if (btb_wr) begin
      valid_q[upd_bidx] <= 1'b1;
      tag_q[upd_bidx]   <= bp.branch_pc_ex[IDX_WIDTH+2 +: TAG_WIDTH];
      tgt_q[upd_bidx]   <= bp.branch_target_pc;
    end
  end

  // The valid read is gated with run so the entry swept on the final INIT
  // edge (still holding its pre-sweep value) cannot produce a stale hit.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      valid_r_q <= 1'b0;
      tag_r_q   <= '0;
      tgt_r_q   <= '0;
      ghr_r_q   <= '0;
    end else begin
      valid_r_q <= run && valid_q[bidx];
      tag_r_q   <= tag_q[bidx];
      tgt_r_q   <= tgt_q[bidx];
      ghr_r_q   <= ghr_q;
    end
  end

  gshare_btb_predictor_sat_counter_table #(
    .ENTRY_NUM (ENTRY_NUM),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pht (
    .clk_i       (cpu_clk),
    .rst_i       (cpu_rst),
    .rd_idx_i    (pidx),
    .rd_cnt_o    (cnt_r),
    .upd_en_i    (upd_en),
    .upd_idx_i   (upd_pidx),
    .upd_taken_i (bp.branch_taken_ex),
    .init_en_i   (init_wr),
    .init_idx_i  (sweep_q)
  );

  assign hit   = run && valid_r_q && (tag_r_q == bp.pc[IDX_WIDTH+2 +: TAG_WIDTH]);
  assign taken = hit && cnt_r[1];

  assign bp.predict_hit       = hit;
  assign bp.predict_taken     = taken;
  assign bp.predict_target_pc = tgt_r_q;
  assign bp.predict_ghr       = ghr_r_q;
  assign bp.init_done         = run;

  // Only index/tag slices of these addresses participate in the lookup.
  assign unused_pc_bits = ^{bp.next_pc, bp.pc, bp.branch_pc_ex};

endmodule

// File: tb/tb_gshare_btb_predictor.sv
module tb_gshare_btb_predictor;

  localparam int unsigned N  = 256;
  localparam int unsigned IW = 8;
  localparam int unsigned TW = 10;

  logic cpu_clk = 1'b0;
  logic cpu_rst;
  always #5 cpu_clk = ~cpu_clk;

  gshare_btb_predictor_if #(.ADDR_WIDTH(32), .GHR_WIDTH(8)) bp_if ();

  gshare_btb_predictor #(
    .ENTRY_NUM  (N),
    .GHR_WIDTH  (8),
    .TAG_WIDTH  (TW),
    .ADDR_WIDTH (32)
  ) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bp      (bp_if)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: plain arrays following the predictor's rules.
  int          m_cnt [N];
  bit          m_val [N];
  int unsigned m_tag [N];
  int unsigned m_tgt [N];
  int unsigned m_ghr;
  bit          m_run;
  int          m_cyc;
  // Expected outputs for the pc currently in fetch
  bit          e_hit, e_taken;
  int unsigned e_tgt, e_ghr;

  logic [31:0] init_pcs [$];

  function automatic int unsigned f_idx(input int unsigned a);
    return (a >> 2) & (N - 1);
  endfunction

  function automatic int unsigned f_tag(input int unsigned a);
    return (a >> (IW + 2)) & ((1 << TW) - 1);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_val[i] = 1'b0;
      m_cnt[i] = 1;
    end
    m_ghr = 0; m_run = 1'b0; m_cyc = 0;
    e_hit = 1'b0; e_taken = 1'b0; e_tgt = 0; e_ghr = 0;
  endfunction

  // Drive one fetch/resolve cycle, advance the model across the edge, then put
  // the looked-up address into pc so predict_* can be sampled.
  task automatic cycle(input logic [31:0] npc, input bit fire, input bit br,
                       input logic [31:0] bpc, input bit btaken,
                       input logic [31:0] btgt, input logic [7:0] bghr,
                       input bit misp);
    int unsigned bi, pi, ui;
    bit          n_hit, n_taken;
    int unsigned n_tgt, n_ghr;
    bp_if.next_pc          = npc;
    bp_if.fetch_fire       = fire;
    bp_if.branch_ex        = br;
    bp_if.branch_pc_ex     = bpc;
    bp_if.branch_taken_ex  = btaken;
    bp_if.branch_target_pc = btgt;
    bp_if.branch_ghr_ex    = bghr;
    bp_if.mispredict_ex    = misp;
    bi      = f_idx(npc);
    pi      = bi ^ m_ghr;
    n_hit   = m_run && m_val[bi] && (m_tag[bi] == f_tag(npc));
    n_taken = n_hit && (m_cnt[pi] >= 2);
    n_tgt   = m_tgt[bi];
    n_ghr   = m_ghr;
    if (m_run) begin
      if (br && misp) m_ghr = ((int'(bghr) << 1) | int'(btaken)) & 255;
      else if (fire && e_hit) m_ghr = ((m_ghr << 1) | int'(e_taken)) & 255;
      if (br) begin
        ui = f_idx(bpc) ^ int'(bghr);
        if (btaken) begin
          if (m_cnt[ui] < 3) m_cnt[ui]++;
          m_val[f_idx(bpc)] = 1'b1;
          m_tag[f_idx(bpc)] = f_tag(bpc);
          m_tgt[f_idx(bpc)] = btgt;
        end else if (m_cnt[ui] > 0) begin
          m_cnt[ui]--;
        end
      end
    end else begin
      m_cyc++;
      if (m_cyc == N) m_run = 1'b1;
    end
    e_hit = n_hit; e_taken = n_taken; e_tgt = n_tgt; e_ghr = n_ghr;
    @(posedge cpu_clk); #1;
    bp_if.pc = npc;
    #1;
  endtask

  task automatic idle(input logic [31:0] npc);
    cycle(npc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0);
  endtask

  task automatic train(input logic [31:0] bpc, input bit tk, input logic [31:0] tgt,
                       input logic [7:0] g);
    cycle(32'h4000, 1'b0, 1'b1, bpc, tk, tgt, g, 1'b0);
  endtask

  task automatic test_reset();
    int n;
    bit got_done;
    bit pulse;
    logic [31:0] a;
    bp_if.next_pc = '0; bp_if.pc = '0; bp_if.fetch_fire = 1'b0;
    bp_if.branch_ex = 1'b0; bp_if.branch_pc_ex = '0; bp_if.branch_taken_ex = 1'b0;
    bp_if.branch_target_pc = '0; bp_if.branch_ghr_ex = '0; bp_if.mispredict_ex = 1'b0;
    cpu_rst = 1'b1;
    repeat (3) @(posedge cpu_clk);
    #1;
    model_reset();
    checks++; if (bp_if.predict_hit !== 1'b0) begin failures++; $display("FAIL reset_hit: got %b expected 0", bp_if.predict_hit); end
    checks++; if (bp_if.predict_taken !== 1'b0) begin failures++; $display("FAIL reset_taken: got %b expected 0", bp_if.predict_taken); end
    checks++; if (bp_if.predict_ghr !== 8'h00) begin failures++; $display("FAIL reset_ghr: got %h expected 00", bp_if.predict_ghr); end
    checks++; if (bp_if.predict_target_pc !== 32'h0) begin failures++; $display("FAIL reset_target: got %h expected 0", bp_if.predict_target_pc); end
    checks++; if (bp_if.init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done: got %b expected 0", bp_if.init_done); end
    cpu_rst = 1'b0;
    // Partial sweep, then reset again: the sweep must restart from index 0.
    for (int i = 0; i < 100; i++) begin
      a = 32'h2000_0000 | (32'($urandom_range(0, 1023)) << 2);
      cycle(a, 1'b0, 1'b1, a, 1'b1, a + 32'h40, 8'($urandom), 1'b0);
      checks++; if (bp_if.predict_hit !== 1'b0) begin failures++; $display("FAIL init_hit_a: got %b expected 0", bp_if.predict_hit); end
    end
    checks++; if (bp_if.init_done !== 1'b0) begin failures++; $display("FAIL init_done_mid: got %b expected 0", bp_if.init_done); end
    cpu_rst = 1'b1;
    @(posedge cpu_clk); #1;
    model_reset();
    cpu_rst = 1'b0;
    n = 0; got_done = 1'b0;
    while (!got_done && n < 400) begin
      a = 32'h2000_0000 | (32'($urandom_range(0, 1023)) << 2);
      pulse = ($urandom_range(0, 3) == 0);
      if (pulse) init_pcs.push_back(a);
      cycle(a, 1'b0, pulse, a, 1'b1, a + 32'h40, 8'($urandom), 1'b0);
      n++;
      checks++; if (bp_if.predict_hit !== 1'b0) begin failures++; $display("FAIL init_hit_b: got %b expected 0 at cycle %0d", bp_if.predict_hit, n); end
      if (bp_if.init_done === 1'b1) got_done = 1'b1;
    end
    checks++;
    if (!got_done || n != 256) begin
      failures++; $display("FAIL init_cycles: got %0d (done=%b) expected 256", n, got_done);
    end
  endtask

  task automatic test_init_ignored();
    for (int i = 0; i < init_pcs.size() && i < 6; i++) begin
      idle(init_pcs[i]);
      checks++; if (bp_if.predict_hit !== 1'b0) begin failures++; $display("FAIL init_ignored: pc %h hit got %b expected 0", init_pcs[i], bp_if.predict_hit); end
    end
  endtask

  task automatic test_train_basic();
    train(32'h100, 1'b1, 32'h200, 8'h00);
    idle(32'h100);
    checks++; if (bp_if.predict_hit !== 1'b1) begin failures++; $display("FAIL basic_hit: got %b expected 1", bp_if.predict_hit); end
    checks++; if (bp_if.predict_target_pc !== 32'h200) begin failures++; $display("FAIL basic_target: got %h expected 200", bp_if.predict_target_pc); end
    checks++; if (bp_if.predict_taken !== 1'b1) begin failures++; $display("FAIL basic_taken: got %b expected 1", bp_if.predict_taken); end
    checks++; if (bp_if.predict_ghr !== 8'h00) begin failures++; $display("FAIL basic_ghr: got %h expected 00", bp_if.predict_ghr); end
  endtask

  task automatic test_saturate();
    repeat (3) train(32'h100, 1'b1, 32'h200, 8'h00);
    train(32'h100, 1'b0, 32'h0, 8'h00);
    idle(32'h100);
    checks++; if (bp_if.predict_taken !== 1'b1) begin failures++; $display("FAIL sat_one_nt: taken got %b expected 1", bp_if.predict_taken); end
    train(32'h100, 1'b0, 32'h0, 8'h00);
    idle(32'h100);
    checks++; if (bp_if.predict_hit !== 1'b1) begin failures++; $display("FAIL sat_hit_kept: got %b expected 1", bp_if.predict_hit); end
    checks++; if (bp_if.predict_taken !== 1'b0) begin failures++; $display("FAIL sat_two_nt: taken got %b expected 0", bp_if.predict_taken); end
    checks++; if (bp_if.predict_target_pc !== 32'h200) begin failures++; $display("FAIL sat_target_kept: got %h expected 200", bp_if.predict_target_pc); end
  endtask

  task automatic test_alias();
    idle(32'h100 + N * 4);
    checks++; if (bp_if.predict_hit !== 1'b0) begin failures++; $display("FAIL alias_hit: got %b expected 0", bp_if.predict_hit); end
    checks++; if (bp_if.predict_taken !== 1'b0) begin failures++; $display("FAIL alias_taken: got %b expected 0", bp_if.predict_taken); end
  endtask

  task automatic test_ghr();
    train(32'h300, 1'b1, 32'h1300, 8'h00);
    train(32'h400, 1'b1, 32'h1400, 8'h00);
    train(32'h500, 1'b1, 32'h1500, 8'h01);
    idle(32'h300);
    checks++; if (bp_if.predict_taken !== 1'b1) begin failures++; $display("FAIL ghr_p1_taken: got %b expected 1", bp_if.predict_taken); end
    cycle(32'h400, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0);
    checks++; if (bp_if.predict_taken !== 1'b1) begin failures++; $display("FAIL ghr_p2_taken: got %b expected 1", bp_if.predict_taken); end
    cycle(32'h500, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0);
    checks++; if (bp_if.predict_taken !== 1'b1) begin failures++; $display("FAIL ghr_p3_taken: got %b expected 1", bp_if.predict_taken); end
    checks++; if (bp_if.predict_ghr !== 8'h01) begin failures++; $display("FAIL ghr_p3_snap: got %h expected 01", bp_if.predict_ghr); end
    cycle(32'h4000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0);
    idle(32'h300);
    checks++; if (bp_if.predict_ghr !== 8'h07) begin failures++; $display("FAIL ghr_three_hits: got %h expected 07", bp_if.predict_ghr); end
    checks++; if (bp_if.predict_hit !== 1'b1) begin failures++; $display("FAIL ghr_hit_before_repair: got %b expected 1", bp_if.predict_hit); end
    cycle(32'h4000, 1'b1, 1'b1, 32'h900, 1'b0, 32'h0, 8'h05, 1'b1);
    idle(32'h4000);
    checks++; if (bp_if.predict_ghr !== 8'h0A) begin failures++; $display("FAIL ghr_repair: got %h expected 0a", bp_if.predict_ghr); end
  endtask

  task automatic test_collision();
    logic [31:0] q;
    q = 32'h680;
    train(q, 1'b1, 32'h5000, 8'(m_ghr ^ 32'h1));
    cycle(q, 1'b0, 1'b1, q, 1'b1, 32'h6000, 8'(m_ghr), 1'b0);
    checks++; if (bp_if.predict_hit !== 1'b1) begin failures++; $display("FAIL coll_hit: got %b expected 1", bp_if.predict_hit); end
    checks++; if (bp_if.predict_taken !== 1'b0) begin failures++; $display("FAIL coll_old_cnt: taken got %b expected 0", bp_if.predict_taken); end
    checks++; if (bp_if.predict_target_pc !== 32'h5000) begin failures++; $display("FAIL coll_old_tgt: got %h expected 5000", bp_if.predict_target_pc); end
    idle(q);
    checks++; if (bp_if.predict_taken !== 1'b1) begin failures++; $display("FAIL coll_new_cnt: taken got %b expected 1", bp_if.predict_taken); end
    checks++; if (bp_if.predict_target_pc !== 32'h6000) begin failures++; $display("FAIL coll_new_tgt: got %h expected 6000", bp_if.predict_target_pc); end
  endtask

  task automatic test_random();
    logic [31:0] pool [8];
    logic [31:0] npc, bpc, tgt;
    logic [7:0]  g;
    for (int i = 0; i < 8; i++) pool[i] = 32'h0001_0000 + (32'($urandom_range(0, 63)) << 2);
    for (int i = 0; i < 400; i++) begin
      npc = ($urandom_range(0, 4) == 0) ? ($urandom & 32'hFFFF_FFFC) : pool[$urandom_range(0, 7)];
      bpc = pool[$urandom_range(0, 7)];
      tgt = $urandom & 32'hFFFF_FFFC;
      g   = ($urandom_range(0, 1) == 0) ? 8'(m_ghr) : 8'($urandom);
      cycle(npc, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4), bpc,
            1'($urandom_range(0, 1)), tgt, g, ($urandom_range(0, 9) < 3));
      checks++; if (bp_if.predict_hit !== e_hit) begin failures++; $display("FAIL rnd_hit[%0d]: got %b expected %b", i, bp_if.predict_hit, e_hit); end
      checks++; if (bp_if.predict_taken !== e_taken) begin failures++; $display("FAIL rnd_taken[%0d]: got %b expected %b", i, bp_if.predict_taken, e_taken); end
      checks++; if (bp_if.predict_ghr !== 8'(e_ghr)) begin failures++; $display("FAIL rnd_ghr[%0d]: got %h expected %h", i, bp_if.predict_ghr, 8'(e_ghr)); end
      if (e_hit) begin
        checks++; if (bp_if.predict_target_pc !== e_tgt) begin failures++; $display("FAIL rnd_tgt[%0d]: got %h expected %h", i, bp_if.predict_target_pc, e_tgt); end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_ignored();
    test_train_basic();
    test_saturate();
    test_alias();
    test_ghr();
    test_collision();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
